kernel_stream_driver: RTL and testbench

Frame sequencer that drives the pixel-stream side of the kernelRam bank in the skeletonization datapath. It buffers one N×N 8-bit frame from the host and replays it as an addressed write stream (we=1). It then sweeps a read stream (we=0) and captures the bank's per-pixel border results into a result buffer that the host can read back. Per-address hold times are sized so each kernelRam samples every address exactly once, whatever its internal alternate-cycle (flip) phase.

---
 rtl/kernel_pkg.sv | 16 +
 rtl/kernel_stream_driver_if.sv | 20 ++
 rtl/pixel_buffer.sv | 34 +++
 rtl/kernel_stream_driver.sv | 149 ++++++++++++++
 tb/tb_kernel_stream_driver.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/kernel_pkg.sv
// Shared types and timing constants for the kernelRam stream driver.
package kernel_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int HOLD_WR    = 2;
  localparam int HOLD_RD    = 3;
  localparam int GAP_CYCLES = 2;

endpackage

// File: rtl/kernel_stream_driver_if.sv
// Addressed pixel stream between the driver and the kernelRam bank.
interface kernel_stream_driver_if #(
  parameter int BIT_SIZE = 6
);
  logic                we;
  logic                re;
  logic [BIT_SIZE:0]   pixel_position_or_address;
  logic [7:0]          data_out;
  logic [7:0]          result_in;

  modport master (
    output we, re, pixel_position_or_address, data_out,
    input  result_in
  );

  modport slave (
    input  we, re, pixel_position_or_address, data_out,
    output result_in
  );
endinterface

// File: rtl/pixel_buffer.sv
// Simple dual-port 8-bit pixel RAM: one write port, one registered read port.
module pixel_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem [DEPTH];
  logic       wr_ok;
  logic       rd_ok;

  assign wr_ok = wr_en && (int'(wr_addr) < DEPTH);
  assign rd_ok = int'(rd_addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr[IDX_W-1:0]] <= wr_data;
  end

  // Write-first on a same-address collision so a freshly loaded pixel is seen at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                rd_data <= '0;
    else if (!rd_ok)                        rd_data <= '0;
    else if (wr_ok && wr_addr == rd_addr)   rd_data <= wr_data;
    else                                    rd_data <= mem[rd_addr[IDX_W-1:0]];
  end
endmodule

// File: rtl/kernel_stream_driver.sv
// Buffers one NxN frame, replays it to the kernelRam bank as a write stream,
// then sweeps a read stream and captures the per-pixel results.
module kernel_stream_driver
  import kernel_pkg::*;
#(
  parameter int N        = 8,
  parameter int BIT_SIZE = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [BIT_SIZE:0]     load_addr,
  input  logic [7:0]            load_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [BIT_SIZE:0]     res_addr,
  output logic [7:0]            res_data,
  kernel_stream_driver_if.master bank
);
  localparam int ADDR_W = BIT_SIZE + 1;
  localparam int DEPTH  = N * N;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [1:0]        hold_reg, hold_next;
  logic              we_reg, we_next;
  logic              re_reg, re_next;
  logic              done_reg, done_next;
  logic              capture;
  logic [7:0]        frame_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      hold_reg  <= '0;
      we_reg    <= 1'b0;
      re_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      hold_reg  <= hold_next;
      we_reg    <= we_next;
      re_reg    <= re_next;
      done_reg  <= done_next;
    end
  end

  // Strobes are computed for the next state so they leave the registers aligned with addr_reg.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    hold_next  = hold_reg;
    we_next    = 1'b0;
    re_next    = 1'b0;
    done_next  = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = WRITE;
          addr_next  = '0;
          hold_next  = '0;
          we_next    = 1'b1;
        end
      end
      WRITE: begin
        we_next = 1'b1;
        if (hold_reg == 2'(HOLD_WR - 1)) begin
          hold_next = '0;
          if (addr_reg == LAST_ADDR) begin
            state_next = GAP;
            addr_next  = '0;
            we_next    = 1'b0;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      GAP: begin
        if (hold_reg == 2'(GAP_CYCLES - 1)) begin
          state_next = READ;
          hold_next  = '0;
          re_next    = 1'b1;
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      READ: begin
        re_next = 1'b1;
        if (hold_reg == 2'(HOLD_RD - 1)) begin
          capture   = 1'b1;
          hold_next = '0;
          if (addr_reg == LAST_ADDR) begin
            state_next = DONE;
            addr_next  = '0;
            re_next    = 1'b0;
            done_next  = 1'b1;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        addr_next  = '0;
        hold_next  = '0;
      end
    endcase
  end

  // Frame read runs one address ahead so its registered output lines up with addr_reg.
  pixel_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_frame_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (load_valid && (state_reg == IDLE)),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (addr_next),
    .rd_data (frame_rd_data)
  );

  pixel_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_result_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_addr (addr_reg),
    .wr_data (bank.result_in),
    .rd_addr (res_addr),
    .rd_data (res_data)
  );

  assign busy                           = (state_reg != IDLE);
  assign done                           = done_reg;
  assign bank.we                        = we_reg;
  assign bank.re                        = re_reg;
  assign bank.pixel_position_or_address = addr_reg;
  assign bank.data_out                  = we_reg ? frame_rd_data : 8'h00;
endmodule

// File: tb/tb_kernel_stream_driver.sv
// Directed-plus-random bench for kernel_stream_driver with a cycle-schedule reference model.
module tb_kernel_stream_driver;
  localparam int NN       = 64;
  localparam int WR_END   = 2 * NN;           // last WRITE cycle
  localparam int RD_START = WR_END + 3;       // first READ cycle
  localparam int RD_END   = RD_START + 3 * NN - 1;
  localparam int DONE_CYC = RD_END + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [6:0] load_addr;
  logic [7:0] load_data;
  logic       start;
  logic       busy;
  logic       done;
  logic [6:0] res_addr;
  logic [7:0] res_data;
  logic [7:0] salt;

  logic [7:0] frame_m  [NN];
  logic [7:0] result_m [NN];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kernel_stream_driver_if #(.BIT_SIZE(6)) bank ();

  kernel_stream_driver #(.N(8), .BIT_SIZE(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .res_addr   (res_addr),
    .res_data   (res_data),
    .bank       (bank)
  );

  // Bank model: result follows the presented address one edge later.
  always @(posedge clk) bank.result_in <= 8'(bank.pixel_position_or_address) + salt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_we"},   32'(bank.we), 32'd0);
    chk({tag, "_re"},   32'(bank.re), 32'd0);
    chk({tag, "_addr"}, 32'(bank.pixel_position_or_address), 32'd0);
    chk({tag, "_data"}, 32'(bank.data_out), 32'd0);
    chk({tag, "_res"},  32'(res_data), 32'd0);
  endtask

  task automatic load_frame();
    for (int i = 0; i < NN; i++) begin
      load_valid = 1'b1;
      load_addr  = 7'(i);
      load_data  = 8'($urandom);
      frame_m[i] = load_data;
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  // Starts a pass from a negedge and checks every cycle against the pass schedule.
  task automatic run_pass(input int abort_at);
    int a_e;
    bit we_e, re_e;
    salt  = 8'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= DONE_CYC + 1; c++) begin
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check_quiet($sformatf("abort_c%0d", c));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      we_e = (c <= WR_END);
      re_e = (c >= RD_START) && (c <= RD_END);
      a_e  = we_e ? (c - 1) / 2 : (re_e ? (c - RD_START) / 3 : 0);
      chk($sformatf("c%0d_busy", c), 32'(busy), 32'(c <= DONE_CYC));
      chk($sformatf("c%0d_done", c), 32'(done), 32'(c == DONE_CYC));
      chk($sformatf("c%0d_we", c),   32'(bank.we), 32'(we_e));
      chk($sformatf("c%0d_re", c),   32'(bank.re), 32'(re_e));
      chk($sformatf("c%0d_addr", c), 32'(bank.pixel_position_or_address), 32'(a_e));
      chk($sformatf("c%0d_data", c), 32'(bank.data_out), we_e ? 32'(frame_m[a_e]) : 32'd0);
      if (re_e && ((c - RD_START) % 3 == 2)) result_m[a_e] = 8'(a_e) + salt;
      // Host pokes while busy must change nothing.
      if (c == 10 || c == 200 || c == DONE_CYC) begin
        start      = 1'b1;
        load_valid = 1'b1;
        load_addr  = 7'($urandom_range(0, NN - 1));
        load_data  = 8'($urandom);
      end else begin
        start      = 1'b0;
        load_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic readback(input string tag);
    for (int k = 0; k < NN; k++) begin
      res_addr = 7'(k);
      @(negedge clk);
      chk($sformatf("%s_res%0d", tag, k), 32'(res_data), 32'(result_m[k]));
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    res_addr   = '0;
    salt       = 8'hA0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    load_frame();
    run_pass(0);
    readback("pass1");

    run_pass(0);
    readback("pass2");

    // Load and start together: the new pixel must appear in this pass.
    load_valid = 1'b1;
    load_addr  = 7'd0;
    load_data  = 8'($urandom);
    frame_m[0] = load_data;
    run_pass(0);

    run_pass(150);
    run_pass(0);
    readback("pass5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
